// File: rtl/warp_ibuffer_if.sv
// Interface bundling the decode-write, scoreboard, arbiter and issue signals
// of the per-warp instruction buffer.
//   master : the surrounding SM pipeline (decode, scoreboard, arbiter, issue)
//   slave  : the instruction buffer itself
// Signals:
//   dec_valid/dec_warp_id/dec_instr  decode write into one warp FIFO
//   ibuf_full                        per-warp FIFO full (back to decode)
//   stall                            per-warp scoreboard hazard
//   flush                            per-warp discard (branch redirect)
//   request                          per-warp issue eligibility (to arbiter)
//   grant_oh                         one-hot grant from arbiter
//   issue_ready                      issue stage accepts this cycle
//   issue_valid/issue_warp_id/issue_instr  granted warp's head instruction
//   overflow_err                     sticky decode-wrote-full-warp flag
interface warp_ibuffer_if #(
  parameter int NUM_WARPS_PER_SM = 4,
  parameter int INSTR_WIDTH      = 32
);
  localparam int WID_W = (NUM_WARPS_PER_SM > 1) ? $clog2(NUM_WARPS_PER_SM) : 1;

  logic                        dec_valid;
  logic [WID_W-1:0]            dec_warp_id;
  logic [INSTR_WIDTH-1:0]      dec_instr;
  logic [NUM_WARPS_PER_SM-1:0] ibuf_full;
  logic [NUM_WARPS_PER_SM-1:0] stall;
  logic [NUM_WARPS_PER_SM-1:0] flush;
  logic [NUM_WARPS_PER_SM-1:0] request;
  logic [NUM_WARPS_PER_SM-1:0] grant_oh;
  logic                        issue_ready;
  logic                        issue_valid;
  logic [WID_W-1:0]            issue_warp_id;
  logic [INSTR_WIDTH-1:0]      issue_instr;
  logic                        overflow_err;

  modport master (
    output dec_valid, dec_warp_id, dec_instr, stall, flush, grant_oh, issue_ready,
    input  ibuf_full, request, issue_valid, issue_warp_id, issue_instr, overflow_err
  );

  modport slave (
    input  dec_valid, dec_warp_id, dec_instr, stall, flush, grant_oh, issue_ready,
    output ibuf_full, request, issue_valid, issue_warp_id, issue_instr, overflow_err
  );
endinterface

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffer for the SM issue stage.
// Decode pushes one instruction per cycle into the FIFO of its warp; each
// non-empty, non-stalled, non-flushed warp raises request. The arbiter's
// one-hot grant selects which warp's head instruction is presented to issue,
// and the head is popped on the issue handshake.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset (counts, pointers, overflow_err)
//   ibus   warp_ibuffer_if.slave (decode, stall/flush, arbiter, issue signals)
module warp_ibuffer #(
  parameter int NUM_WARPS_PER_SM = 4,
  parameter int IBUF_DEPTH       = 4,
  parameter int INSTR_WIDTH      = 32
) (
  input  logic          clk,
  input  logic          reset,
  warp_ibuffer_if.slave ibus
);
  localparam int NW    = NUM_WARPS_PER_SM;
  localparam int WID_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

  logic [INSTR_WIDTH-1:0] mem    [NW][IBUF_DEPTH];
  logic [CNT_W-1:0]       count  [NW];
  logic [PTR_W-1:0]       rd_ptr [NW];
  logic [PTR_W-1:0]       wr_ptr [NW];
  logic                   overflow_q;

  logic [NW-1:0]    full;
  logic [NW-1:0]    req;
  logic [NW-1:0]    sel;
  logic [NW-1:0]    push;
  logic [NW-1:0]    pop;
  logic [WID_W-1:0] gidx;
  logic             reject;

  // Lowest set bit wins, so an illegal multi-hot grant still yields a
  // deterministic warp index.
  function automatic logic [WID_W-1:0] lowest_set(input logic [NW-1:0] v);
    lowest_set = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = WID_W'(i);
    end
  endfunction

  always_comb begin
    full = '0;
    req  = '0;
    push = '0;
    for (int w = 0; w < NW; w++) begin
      full[w] = (count[w] == CNT_W'(IBUF_DEPTH));
      req[w]  = (count[w] != '0) & ~ibus.stall[w] & ~ibus.flush[w];
      // A full warp rejects the push even if it pops this cycle.
      push[w] = ibus.dec_valid & (ibus.dec_warp_id == WID_W'(w))
              & ~full[w] & ~ibus.flush[w];
    end
  end

  assign sel  = ibus.grant_oh & req;
  assign pop  = sel & {NW{ibus.issue_ready}};
  assign gidx = lowest_set(ibus.grant_oh);

  // A push dropped because of a same-cycle flush is not an overflow.
  assign reject = ibus.dec_valid & full[ibus.dec_warp_id] & ~ibus.flush[ibus.dec_warp_id];

  assign ibus.ibuf_full     = full;
  assign ibus.request       = req;
  assign ibus.issue_valid   = |sel;
  assign ibus.issue_warp_id = gidx;
  assign ibus.issue_instr   = mem[gidx][rd_ptr[gidx]];
  assign ibus.overflow_err  = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NW; w++) begin
        count[w]  <= '0;
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (ibus.flush[w]) begin
          count[w]  <= '0;
          rd_ptr[w] <= '0;
          wr_ptr[w] <= '0;
        end else begin
          if (push[w]) wr_ptr[w] <= wr_ptr[w] + PTR_W'(1);
          if (pop[w])  rd_ptr[w] <= rd_ptr[w] + PTR_W'(1);
          case ({push[w], pop[w]})
            2'b10:   count[w] <= count[w] + CNT_W'(1);
            2'b01:   count[w] <= count[w] - CNT_W'(1);
            default: ;
          endcase
        end
      end
      if (reject) overflow_q <= 1'b1;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (push[w]) mem[w][wr_ptr[w]] <= ibus.dec_instr;
    end
  end
endmodule

// File: tb/tb_warp_ibuffer.sv
module tb_warp_ibuffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  warp_ibuffer_if #(.NUM_WARPS_PER_SM(4), .INSTR_WIDTH(32)) ibus ();

  warp_ibuffer #(.NUM_WARPS_PER_SM(4), .IBUF_DEPTH(4), .INSTR_WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .ibus (ibus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [33:0] sb[$];
  logic [33:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issue handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && ibus.issue_valid === 1'b1 && ibus.issue_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_issue: got warp %0d instr %h, expected no issue",
                 ibus.issue_warp_id, ibus.issue_instr);
      end else begin
        mon_exp = sb.pop_front();
        if ({ibus.issue_warp_id, ibus.issue_instr} !== mon_exp) begin
          n_bad++;
          $display("FAIL issue: got warp %0d instr %h, expected warp %0d instr %h",
                   ibus.issue_warp_id, ibus.issue_instr, mon_exp[33:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [1:0] w, input logic [31:0] instr);
    ibus.dec_valid   = 1'b1;
    ibus.dec_warp_id = w;
    ibus.dec_instr   = instr;
    cyc();
    ibus.dec_valid = 1'b0;
  endtask

  task automatic issue_w(input logic [1:0] w, input logic [31:0] instr);
    ibus.grant_oh    = 4'b0001 << w;
    ibus.issue_ready = 1'b1;
    sb.push_back({w, instr});
    cyc();
    ibus.grant_oh    = 4'b0000;
    ibus.issue_ready = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    ibus.dec_valid   = 1'b0;
    ibus.dec_warp_id = 2'd0;
    ibus.dec_instr   = 32'h0;
    ibus.stall       = 4'b0000;
    ibus.flush       = 4'b0000;
    ibus.grant_oh    = 4'b0000;
    ibus.issue_ready = 1'b0;
    #1;
    chk("reset_request", 32'(ibus.request), 32'h0);
    chk("reset_full", 32'(ibus.ibuf_full), 32'h0);
    chk("reset_issue_valid", 32'(ibus.issue_valid), 32'h0);
    chk("reset_overflow", 32'(ibus.overflow_err), 32'h0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // 1: two entries on warp 2 issue in order
    push_w(2'd2, 32'hA000_000A);
    #1;
    chk("t1_request_after_push", 32'(ibus.request), 32'h4);
    push_w(2'd2, 32'hB000_000B);
    issue_w(2'd2, 32'hA000_000A);
    issue_w(2'd2, 32'hB000_000B);
    #1;
    chk("t1_request_empty", 32'(ibus.request), 32'h0);

    // 2: fill warp 0, overflow, drain
    for (int i = 0; i < 4; i++) push_w(2'd0, 32'h100 + 32'(i));
    #1;
    chk("t2_full", 32'(ibus.ibuf_full), 32'h1);
    chk("t2_no_overflow_yet", 32'(ibus.overflow_err), 32'h0);
    push_w(2'd0, 32'h104);
    #1;
    chk("t2_overflow", 32'(ibus.overflow_err), 32'h1);
    chk("t2_still_full", 32'(ibus.ibuf_full), 32'h1);
    for (int i = 0; i < 4; i++) issue_w(2'd0, 32'h100 + 32'(i));
    #1;
    chk("t2_request_empty", 32'(ibus.request), 32'h0);
    chk("t2_overflow_sticky", 32'(ibus.overflow_err), 32'h1);
    chk("t2_full_clear", 32'(ibus.ibuf_full), 32'h0);

    // 3: push+pop on full warp 1 rejects push; at count 2 both happen
    for (int i = 0; i < 4; i++) push_w(2'd1, 32'h200 + 32'(i));
    ibus.dec_valid   = 1'b1;
    ibus.dec_warp_id = 2'd1;
    ibus.dec_instr   = 32'h2FF;
    ibus.grant_oh    = 4'b0010;
    ibus.issue_ready = 1'b1;
    sb.push_back({2'd1, 32'h200});
    cyc();
    ibus.dec_valid   = 1'b0;
    ibus.grant_oh    = 4'b0000;
    ibus.issue_ready = 1'b0;
    #1;
    chk("t3_count3_not_full", 32'(ibus.ibuf_full), 32'h0);
    chk("t3_overflow", 32'(ibus.overflow_err), 32'h1);
    for (int i = 1; i < 4; i++) issue_w(2'd1, 32'h200 + 32'(i));
    #1;
    chk("t3_rejected_push_absent", 32'(ibus.request), 32'h0);
    push_w(2'd1, 32'h210);
    push_w(2'd1, 32'h211);
    ibus.dec_valid   = 1'b1;
    ibus.dec_warp_id = 2'd1;
    ibus.dec_instr   = 32'h212;
    ibus.grant_oh    = 4'b0010;
    ibus.issue_ready = 1'b1;
    sb.push_back({2'd1, 32'h210});
    cyc();
    ibus.dec_valid   = 1'b0;
    ibus.grant_oh    = 4'b0000;
    ibus.issue_ready = 1'b0;
    issue_w(2'd1, 32'h211);
    issue_w(2'd1, 32'h212);
    #1;
    chk("t3_drained", 32'(ibus.request), 32'h0);

    // 4: stall masks request and issue
    push_w(2'd3, 32'h300);
    push_w(2'd3, 32'h301);
    ibus.stall       = 4'b1000;
    ibus.grant_oh    = 4'b1000;
    ibus.issue_ready = 1'b1;
    #1;
    chk("t4_stalled_request", 32'(ibus.request), 32'h0);
    chk("t4_stalled_valid", 32'(ibus.issue_valid), 32'h0);
    cyc();
    ibus.stall = 4'b0000;
    sb.push_back({2'd3, 32'h300});
    cyc();
    issue_w(2'd3, 32'h301);
    #1;
    chk("t4_drained", 32'(ibus.request), 32'h0);

    // 5: flush beats push and pop; no overflow from a flushed push
    reset = 1'b1;
    #1;
    chk("t5_reset_clears_overflow", 32'(ibus.overflow_err), 32'h0);
    cyc();
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) push_w(2'd0, 32'h400 + 32'(i));
    push_w(2'd2, 32'h420);
    ibus.flush       = 4'b0001;
    ibus.dec_valid   = 1'b1;
    ibus.dec_warp_id = 2'd0;
    ibus.dec_instr   = 32'h4FF;
    ibus.grant_oh    = 4'b0001;
    ibus.issue_ready = 1'b1;
    #1;
    chk("t5_flush_valid", 32'(ibus.issue_valid), 32'h0);
    chk("t5_flush_request", 32'(ibus.request), 32'h4);
    cyc();
    ibus.flush       = 4'b0000;
    ibus.dec_valid   = 1'b0;
    ibus.grant_oh    = 4'b0000;
    ibus.issue_ready = 1'b0;
    #1;
    chk("t5_after_flush_request", 32'(ibus.request), 32'h4);
    chk("t5_after_flush_overflow", 32'(ibus.overflow_err), 32'h0);
    push_w(2'd0, 32'h410);
    issue_w(2'd0, 32'h410);
    issue_w(2'd2, 32'h420);
    #1;
    chk("t5_drained", 32'(ibus.request), 32'h0);

    // 6: grant without request, then async reset mid-stream
    ibus.grant_oh    = 4'b0001;
    ibus.issue_ready = 1'b1;
    #1;
    chk("t6_grant_no_request", 32'(ibus.issue_valid), 32'h0);
    chk("t6_warp_id", 32'(ibus.issue_warp_id), 32'h0);
    cyc();
    ibus.grant_oh    = 4'b0000;
    ibus.issue_ready = 1'b0;
    push_w(2'd0, 32'h601);
    issue_w(2'd0, 32'h601);
    push_w(2'd0, 32'h600);
    push_w(2'd1, 32'h610);
    push_w(2'd3, 32'h630);
    for (int i = 0; i < 4; i++) push_w(2'd2, 32'h620 + 32'(i));
    #1;
    chk("t6_all_request", 32'(ibus.request), 32'hF);
    chk("t6_full_w2", 32'(ibus.ibuf_full), 32'h4);
    ibus.grant_oh = 4'b0010;
    reset = 1'b1;
    #1;
    chk("t6_async_request", 32'(ibus.request), 32'h0);
    chk("t6_async_full", 32'(ibus.ibuf_full), 32'h0);
    chk("t6_async_valid", 32'(ibus.issue_valid), 32'h0);
    cyc();
    reset = 1'b0;
    ibus.grant_oh = 4'b0000;
    cyc();
    chk("t6_post_reset_request", 32'(ibus.request), 32'h0);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
